// File: rtl/ahb_pkg.sv
// Shared AHB definitions: arbiter state encoding, HTRANS codes and the
// master-index width used by the arbiter and its round-robin picker.
package ahb_pkg;

    // Widest master vector the arbiter supports; narrower configurations
    // are zero-extended to this width wherever an index is looked up.
    localparam int MAX_MASTERS = 4;
    localparam int MIDX_W      = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_LOCKED = 2'd2
    } arb_state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // Index of the set bit in a one-hot vector (0 for an all-zero vector).
    function automatic logic [MIDX_W-1:0] oh_to_idx(input logic [MAX_MASTERS-1:0] oh);
        logic [MIDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_MASTERS; i++) begin
            if (oh[i]) begin
                idx = MIDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// Combinational round-robin picker: first requester (not excluded) found by
// searching circularly from ptr+1. The pointer itself is checked last.
module ahb_rr_pick
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS = 4
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [MIDX_W-1:0]      ptr,
    input  logic [NUM_MASTERS-1:0] excl,
    output logic [NUM_MASTERS-1:0] win,
    output logic                   vld
);

    logic [NUM_MASTERS-1:0] cand;
    logic [MIDX_W-1:0]      sel;
    int                     pos;

    assign cand = req & ~excl;

    // Circular priority scan; the first hit wins and blocks later hits.
    always_comb begin
        win = '0;
        vld = 1'b0;
        sel = '0;
        pos = 0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            pos = (int'(ptr) + 1 + i) % NUM_MASTERS;
            sel = MIDX_W'(pos);
            if (!vld && cand[sel]) begin
                win[sel] = 1'b1;
                vld      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_arbiter.sv
// AHB bus arbiter: round-robin among requesters with a hold limit for
// unlocked owners, locked sequences that block handover, and a parked
// default master. Everything advances only on cycles where hReadyout=1.
module ahb_arbiter
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int MAX_HOLD    = 16,
    parameter int DEF_MASTER  = 0
) (
    input  logic                   hClk,
    input  logic                   hRst,
    input  logic [NUM_MASTERS-1:0] hBusreq,
    input  logic [NUM_MASTERS-1:0] hLock,
    input  logic                   hReadyout,
    output logic [NUM_MASTERS-1:0] hGrant,
    output logic [1:0]             hMaster,
    output logic                   hMastlock
);

    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0]      HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [NUM_MASTERS-1:0] DEF_OH    = NUM_MASTERS'(1) << DEF_MASTER;
    localparam logic [MIDX_W-1:0]      DEF_IDX   = MIDX_W'(DEF_MASTER);

    arb_state_e             state, state_nxt;
    logic [MIDX_W-1:0]      ptr, ptr_nxt;
    logic [HOLD_W-1:0]      hold_cnt, hold_nxt;
    logic [NUM_MASTERS-1:0] grant_nxt;
    logic [NUM_MASTERS-1:0] excl;
    logic [NUM_MASTERS-1:0] win;
    logic                   win_vld;
    logic                   rearb;

    logic [MAX_MASTERS-1:0] req_all;
    logic [MAX_MASTERS-1:0] lock_all;
    logic                   owner_req;
    logic                   owner_lock;
    logic [MIDX_W-1:0]      grant_idx;
    logic [MIDX_W-1:0]      win_idx;

    // While a master owns the bus the pointer always equals its index, so
    // the owner's request/lock bits are looked up through the pointer.
    assign req_all    = MAX_MASTERS'(hBusreq);
    assign lock_all   = MAX_MASTERS'(hLock);
    assign owner_req  = req_all[ptr];
    assign owner_lock = lock_all[ptr];
    assign grant_idx  = oh_to_idx(MAX_MASTERS'(hGrant));
    assign win_idx    = oh_to_idx(MAX_MASTERS'(win));

    // Owner that has used up its hold budget is kept out of the search.
    always_comb begin
        excl = '0;
        if (state == ST_GRANT && owner_req && !owner_lock && hold_cnt == HOLD_LAST) begin
            excl = NUM_MASTERS'(1) << ptr;
        end
    end

    ahb_rr_pick #(
        .NUM_MASTERS(NUM_MASTERS)
    ) u_pick (
        .req (hBusreq),
        .ptr (ptr),
        .excl(excl),
        .win (win),
        .vld (win_vld)
    );

    // Next-state: decide between keeping the owner, locking, or rearbitrating.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        hold_nxt  = hold_cnt;
        grant_nxt = hGrant;
        rearb     = 1'b0;
        if (hReadyout) begin
            unique case (state)
                ST_LOCKED: begin
                    rearb = !owner_lock;
                end
                ST_GRANT: begin
                    if (owner_lock) begin
                        state_nxt = ST_LOCKED;
                    end else if (owner_req && hold_cnt != HOLD_LAST) begin
                        hold_nxt = hold_cnt + HOLD_W'(1);
                    end else if (owner_req && !win_vld) begin
                        // Budget exhausted but nobody else waiting: stay, saturated.
                        hold_nxt = hold_cnt;
                    end else begin
                        rearb = 1'b1;
                    end
                end
                default: begin
                    rearb = 1'b1;
                end
            endcase

            if (rearb) begin
                if (win_vld) begin
                    state_nxt = ST_GRANT;
                    grant_nxt = win;
                    ptr_nxt   = win_idx;
                    if (state == ST_IDLE || win_idx != ptr) begin
                        hold_nxt = '0;
                    end else if (hold_cnt != HOLD_LAST) begin
                        hold_nxt = hold_cnt + HOLD_W'(1);
                    end
                end else begin
                    state_nxt = ST_IDLE;
                    grant_nxt = DEF_OH;
                    hold_nxt  = '0;
                end
            end
        end
    end

    // Arbitration state: FSM state, round-robin pointer and hold counter.
    always_ff @(posedge hClk or negedge hRst) begin
        if (!hRst) begin
            state    <= ST_IDLE;
            ptr      <= DEF_IDX;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    // Output registers; hMaster/hMastlock trail hGrant by one ready cycle.
    always_ff @(posedge hClk or negedge hRst) begin
        if (!hRst) begin
            hGrant    <= DEF_OH;
            hMaster   <= DEF_IDX;
            hMastlock <= 1'b0;
        end else begin
            hGrant <= grant_nxt;
            if (hReadyout) begin
                hMaster   <= grant_idx;
                hMastlock <= lock_all[grant_idx];
            end
        end
    end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter: each step drives one cycle of inputs and
// queues the hand-computed outputs expected after the following edge; an
// independent monitor pops and compares after every clock edge.
`timescale 1ns/1ps
module tb_ahb_arbiter;

    logic       hClk = 1'b0;
    logic       hRst;
    logic [3:0] hBusreq;
    logic [3:0] hLock;
    logic       hReadyout;
    logic [3:0] hGrant;
    logic [1:0] hMaster;
    logic       hMastlock;

    typedef struct {
        logic [3:0] g;
        logic [1:0] m;
        logic       ml;
        int         tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    ahb_arbiter #(
        .NUM_MASTERS(4),
        .MAX_HOLD   (16),
        .DEF_MASTER (0)
    ) dut (
        .hClk     (hClk),
        .hRst     (hRst),
        .hBusreq  (hBusreq),
        .hLock    (hLock),
        .hReadyout(hReadyout),
        .hGrant   (hGrant),
        .hMaster  (hMaster),
        .hMastlock(hMastlock)
    );

    always #5 hClk = ~hClk;

    task automatic check_val(input string name, input int tag,
                             input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h, expected %0h", name, tag, act, req);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(input logic [3:0] br, input logic [3:0] lk, input logic rdy,
                        input logic [3:0] eg, input logic [1:0] em, input logic eml,
                        input int tag);
        exp_t e;
        @(posedge hClk);
        #2;
        hBusreq   = br;
        hLock     = lk;
        hReadyout = rdy;
        e.g   = eg;
        e.m   = em;
        e.ml  = eml;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    // Monitor: compare after every edge that has an expectation pending.
    initial begin
        exp_t e;
        forever begin
            @(posedge hClk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_val("hGrant",    e.tag, 32'(hGrant),    32'(e.g));
                check_val("hMaster",   e.tag, 32'(hMaster),   32'(e.m));
                check_val("hMastlock", e.tag, 32'(hMastlock), 32'(e.ml));
            end
        end
    end

    initial begin
        logic [3:0] g;
        logic [3:0] prev;
        logic [3:0] fr_br [5];
        logic [3:0] fr_lk [5];

        hRst      = 1'b0;
        hBusreq   = 4'b0000;
        hLock     = 4'b0000;
        hReadyout = 1'b1;

        // Reset values while held in reset
        #12;
        check_val("rst_grant", 0, 32'(hGrant),    32'h1);
        check_val("rst_master", 0, 32'(hMaster),  32'h0);
        check_val("rst_mlock", 0, 32'(hMastlock), 32'h0);
        @(posedge hClk);
        #3;
        hRst = 1'b1;

        // No requests: default master stays parked
        for (int k = 0; k < 4; k++) begin
            step(4'b0000, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b0, 100 + k);
        end

        // Round robin from pointer 0, then owner 1 drops
        step(4'b1010, 4'b0000, 1'b1, 4'b0010, 2'd0, 1'b0, 200);
        step(4'b1010, 4'b0000, 1'b1, 4'b0010, 2'd1, 1'b0, 201);
        step(4'b1000, 4'b0000, 1'b1, 4'b1000, 2'd1, 1'b0, 202);
        step(4'b1000, 4'b0000, 1'b1, 4'b1000, 2'd3, 1'b0, 203);
        step(4'b0000, 4'b0000, 1'b1, 4'b0001, 2'd3, 1'b0, 204);
        step(4'b0000, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b0, 205);

        // Two constant requesters alternate every 16 ready cycles
        prev = 4'b0001;
        for (int k = 1; k <= 48; k++) begin
            g = (((k - 1) / 16) % 2 == 0) ? 4'b0001 : 4'b0010;
            step(4'b0011, 4'b0000, 1'b1, g, (prev == 4'b0001) ? 2'd0 : 2'd1, 1'b0, 300 + k);
            prev = g;
        end
        // Master 0 alone keeps the bus with its budget used up
        for (int k = 0; k < 20; k++) begin
            step(4'b0001, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b0, 400 + k);
        end
        // Saturated owner yields at once when master 1 reappears
        step(4'b0011, 4'b0000, 1'b1, 4'b0010, 2'd0, 1'b0, 450);
        step(4'b0000, 4'b0000, 1'b1, 4'b0001, 2'd1, 1'b0, 451);
        step(4'b0000, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b0, 452);

        // Locked owner 2 ignores the hold limit and other requests
        step(4'b0100, 4'b0000, 1'b1, 4'b0100, 2'd0, 1'b0, 500);
        for (int k = 0; k < 40; k++) begin
            step(4'b1111, 4'b0101, 1'b1, 4'b0100, 2'd2, 1'b1, 510 + k);
        end
        step(4'b1111, 4'b0000, 1'b1, 4'b1000, 2'd2, 1'b0, 560);
        step(4'b1111, 4'b0000, 1'b1, 4'b1000, 2'd3, 1'b0, 561);
        // A non-owner's lock does not lock the bus
        step(4'b1111, 4'b0001, 1'b1, 4'b1000, 2'd3, 1'b0, 562);

        // Not-ready cycles freeze everything
        fr_br[0] = 4'b0001; fr_lk[0] = 4'b1000;
        fr_br[1] = 4'b0110; fr_lk[1] = 4'b0000;
        fr_br[2] = 4'b0000; fr_lk[2] = 4'b1000;
        fr_br[3] = 4'b1001; fr_lk[3] = 4'b0110;
        fr_br[4] = 4'b0100; fr_lk[4] = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            step(fr_br[k], fr_lk[k], 1'b0, 4'b1000, 2'd3, 1'b0, 600 + k);
        end
        step(4'b0110, 4'b0000, 1'b1, 4'b0010, 2'd3, 1'b0, 610);
        step(4'b0110, 4'b0000, 1'b1, 4'b0010, 2'd1, 1'b0, 611);

        // Master 3 locked, then reset mid-lock
        step(4'b1000, 4'b0000, 1'b1, 4'b1000, 2'd1, 1'b0, 700);
        step(4'b1000, 4'b1000, 1'b1, 4'b1000, 2'd3, 1'b1, 701);
        step(4'b1000, 4'b1000, 1'b1, 4'b1000, 2'd3, 1'b1, 702);
        @(posedge hClk);
        #3;
        hRst = 1'b0;
        #1;
        check_val("async_rst_grant", 710, 32'(hGrant),    32'h1);
        check_val("async_rst_master", 710, 32'(hMaster),  32'h0);
        check_val("async_rst_mlock", 710, 32'(hMastlock), 32'h0);
        hBusreq = 4'b0000;
        hLock   = 4'b0000;
        @(posedge hClk);
        #1;
        check_val("held_rst_grant", 711, 32'(hGrant), 32'h1);
        @(posedge hClk);
        #3;
        hRst = 1'b1;
        // Arbitration restarts from the default-master pointer
        step(4'b1100, 4'b0000, 1'b1, 4'b0100, 2'd0, 1'b0, 720);
        step(4'b1100, 4'b0000, 1'b1, 4'b0100, 2'd2, 1'b0, 721);

        // Every queued expectation must have been consumed
        repeat (3) @(posedge hClk);
        #3;
        check_val("queue_drained", 800, 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_arbiter.md
AHB_ARBITER -- requirements
Module: ahb_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 4: number of requesting masters (2..4).
REQ-002 Parameter MAX_HOLD, default 16: maximum ready cycles one unlocked owner keeps the bus while others wait.
REQ-003 Parameter DEF_MASTER, default 0: master granted when nobody requests.
REQ-004 hClk  input  1  single clock; all state updates on rising edge.
REQ-005 hRst  input  1  reset; asynchronous, active-low.
REQ-006 hBusreq  input  NUM_MASTERS  per-master bus request, level-sensitive.
REQ-007 hLock  input  NUM_MASTERS  per-master locked-transfer request.
REQ-008 hReadyout  input  1  slave ready; 1 = current data phase completes this cycle.
REQ-009 hGrant  output  NUM_MASTERS  registered one-hot grant.
REQ-010 hMaster  output  2  registered index of master owning the address phase.
REQ-011 hMastlock  output  1  registered; current address-phase owner holds a locked sequence.

Function
REQ-012 States: IDLE (default master parked, no request), GRANT (requester owns bus), LOCKED (owner's hLock set, no handover).
REQ-013 Arbitration is evaluated only in cycles with hReadyout=1; with hReadyout=0 hGrant, hMaster, hMastlock, state, pointer and hold counter all hold.
REQ-014 Winner = first index with hBusreq=1 searching circularly from (last owner + 1) mod NUM_MASTERS; grant registered, visible the cycle after evaluation.
REQ-015 No hBusreq set -> hGrant = one-hot(DEF_MASTER), state IDLE, pointer unchanged.
REQ-016 GRANT: owner keeps grant while hBusreq[owner]=1 and hold counter < MAX_HOLD-1; owner drop -> rearbitrate same cycle.
REQ-017 Hold counter increments each ready cycle in GRANT, clears on any change of owner; at MAX_HOLD-1 with another request pending, owner is excluded and next round-robin requester wins.
REQ-018 At MAX_HOLD-1 with no other request pending, owner keeps grant and counter saturates at MAX_HOLD-1.
REQ-019 GRANT -> LOCKED when hLock[owner]=1 on a ready cycle; LOCKED ignores hold counter and other requests.
REQ-020 LOCKED -> GRANT/IDLE arbitration on first ready cycle with hLock[owner]=0; hLock of non-owners is ignored.
REQ-021 hMaster <= index(hGrant) and hMastlock <= hLock[index(hGrant)] on ready cycles, i.e. one ready cycle behind hGrant (address-phase alignment).
REQ-022 hGrant is always exactly one-hot; indices >= NUM_MASTERS never granted.
REQ-023 Simultaneous owner drop and new requests: handover in that cycle, no IDLE bubble.

Reset
REQ-024 hRst=0 asynchronously forces: hGrant = one-hot(DEF_MASTER), hMaster = DEF_MASTER, hMastlock = 0, state IDLE, pointer = DEF_MASTER, hold counter 0.
REQ-025 Reset mid-transfer or mid-lock abandons ownership; first ready cycle after release arbitrates from pointer = DEF_MASTER.

Structure
REQ-026 Shared package ahb_pkg holds state encoding (IDLE/GRANT/LOCKED), HTRANS constants and the master-index width.
REQ-027 Round-robin search is one combinational sub-module ahb_rr_pick (request vector, pointer, exclude mask -> one-hot winner, valid).
REQ-028 Arbiter top holds state register, pointer, hold counter and output registers only.

Verification
REQ-029 Reset release, no requests -> hGrant=4'b0001, hMaster=0, hMastlock=0 held indefinitely.
REQ-030 hBusreq=4'b1010, hReadyout=1 from pointer 0 -> hGrant=4'b0010 next cycle, hMaster=1 one cycle later; master 1 drops -> hGrant=4'b1000.
REQ-031 hBusreq=4'b0011 constant, MAX_HOLD=16 -> grant alternates 0,1 every 16 ready cycles; master 0 alone -> holds indefinitely.
REQ-032 Owner 2 asserts hLock[2] with hBusreq=4'b1111 for 40 cycles -> hGrant stays 4'b0100, hMastlock=1; hLock[2] drops -> hGrant=4'b1000.
REQ-033 hReadyout=0 for 5 cycles while requests change -> all outputs frozen; resume on hReadyout=1.
REQ-034 hRst pulsed low while master 3 locked -> immediate hGrant=4'b0001, hMastlock=0; after release hBusreq=4'b1100 -> hGrant=4'b0100.
